// File: rtl/edge_mask_pkg.sv
// edge_mask_pkg: shared constants and types for the edge-mask ROM arbiter.
package edge_mask_pkg;
   localparam int AW = 12;
   localparam int DW = 2048;
   localparam int RW = 32;
   localparam int WORD_IDX_W = 6;
   localparam int ID_W = 3;

   typedef logic [AW-1:0] xyz_t;

   typedef struct packed {
      logic                  valid;
      logic [ID_W-1:0]       id;
      logic [WORD_IDX_W-1:0] word;
   } pipe_entry_t;
endpackage

// File: rtl/edge_mask_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first eligible index at or after ptr_i.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  elig_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] back;
   logic [N-1:0]   rot;
   logic [N-1:0]   low;

   // Rotate so ptr_i sits at bit 0, keep the lowest set bit, rotate back.
   always_comb begin
      dbl   = {elig_i, elig_i} >> ptr_i;
      rot   = dbl[N-1:0];
      low   = rot & (~rot + N'(1));
      back  = {low, low} << ptr_i;
      gnt_o = back[2*N-1:N];
   end
endmodule

// File: rtl/edge_mask_arb.sv
// edge_mask_arb: round-robin sharing of the edge-mask ROM, returning one 32-bit slice per request.
// Optional EDGE_MASK_ARB_PERF_EN adds perf_cnt, a saturating 16-bit grant counter per requester.
module edge_mask_arb
   import edge_mask_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ROM_LAT = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*AW-1:0]          req_xyz,
   input  logic [N_REQ*WORD_IDX_W-1:0]  req_word,
   output logic [AW-1:0]                rom_addr,
   input  logic [DW-1:0]                rom_dout,
   output logic [N_REQ-1:0]             rsp_valid,
   output logic [RW-1:0]                rsp_data,
   output logic                         busy
`ifdef EDGE_MASK_ARB_PERF_EN
   ,
   output logic [N_REQ*16-1:0]          perf_cnt
`endif
);
   localparam int PW = $clog2(N_REQ);
   localparam int SW = $clog2(RW);

   logic [PW-1:0]         rr_ptr_q, rr_ptr_d, gidx;
   logic [N_REQ-1:0]      out_q, out_d, rsp_valid_q, rsp_valid_d, elig, gnt;
   logic [RW-1:0]         rsp_data_q, rsp_data_d;
   xyz_t                  rom_addr_q;
   xyz_t                  xyz [N_REQ];
   logic [WORD_IDX_W-1:0] word [N_REQ];
   pipe_entry_t           pipe_q [ROM_LAT];
   pipe_entry_t           head, tail;
   logic                  hs;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         xyz[i]  = req_xyz[i*AW +: AW];
         word[i] = req_word[i*WORD_IDX_W +: WORD_IDX_W];
      end
   end

   assign elig = req_valid & ~out_q;

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
      .elig_i (elig),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (gnt)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) if (gnt[i]) gidx = PW'(i);
   end

   assign req_ready = RST ? '0 : gnt;
   assign hs        = |(req_valid & req_ready);
   assign rom_addr  = hs ? xyz[gidx] : rom_addr_q;
   assign tail      = pipe_q[ROM_LAT-1];

   always_comb begin
      head        = '{valid: hs, id: ID_W'(gidx), word: word[gidx]};
      rr_ptr_d    = !hs ? rr_ptr_q : (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
      out_d       = (out_q & ~rsp_valid_q) | (req_valid & req_ready);
      rsp_valid_d = tail.valid ? N_REQ'(1) << tail.id : '0;
      rsp_data_d  = tail.valid ? rom_dout[{tail.word, SW'(0)} +: RW] : rsp_data_q;
   end

   always_comb begin
      busy = |out_q;
      for (int s = 0; s < ROM_LAT; s++) busy = busy | pipe_q[s].valid;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr_q    <= '0;
         out_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rom_addr_q  <= '0;
         for (int s = 0; s < ROM_LAT; s++) pipe_q[s] <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_q       <= out_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rom_addr_q  <= rom_addr;
         pipe_q[0]   <= head;
         for (int s = 1; s < ROM_LAT; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

`ifdef EDGE_MASK_ARB_PERF_EN
   logic [15:0] cnt_q [N_REQ];

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (req_valid[i] && req_ready[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
   end

   always_comb begin
      perf_cnt = '0;
      for (int i = 0; i < N_REQ; i++) perf_cnt[i*16 +: 16] = cnt_q[i];
   end
`endif
endmodule
